// File: rtl/rv_plic_core_mt.sv
// Multi-target PLIC core: per-source gateways, registered per-target arbiters, claim/complete.
// Build option RV_PLIC_EDGE_CNT_EN queues edges that arrive while a source is pending or in service.
module rv_plic_core_mt #(
    parameter int NumSrc    = 32,
    parameter int NumTarget = 2,
    parameter int MaxPrio   = 7,
    localparam int PRIOW    = $clog2(MaxPrio + 1),
    localparam int SRCW     = $clog2(NumSrc)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumSrc-1:0]           intr_src_i,
    input  logic [NumSrc-1:0]           le_i,
    input  logic [NumSrc*PRIOW-1:0]     prio_i,
    input  logic [NumTarget*NumSrc-1:0] ie_i,
    input  logic [NumTarget*PRIOW-1:0]  threshold_i,
    input  logic [NumTarget-1:0]        claim_i,
    input  logic [NumTarget-1:0]        complete_i,
    input  logic [NumTarget*SRCW-1:0]   complete_id_i,
    output logic [NumSrc-1:0]           ip_o,
    output logic [NumTarget-1:0]        irq_o,
    output logic [NumTarget*SRCW-1:0]   irq_id_o
);
    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    logic [NumSrc-1:0] src_q_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q_reg <= '0;
        end else begin
            src_q_reg <= intr_src_i;
        end
    end

    genvar gi;
    for (gi = 0; gi < NumSrc; gi++) begin : g_gw
        if (gi == 0) begin : g_rsvd
            // ID 0 means "no interrupt", so its gateway never leaves IDLE.
            logic unused_rsvd;
            assign unused_rsvd = ^{intr_src_i[0], le_i[0], src_q_reg[0], prio_i[PRIOW-1:0]};
            assign ip_o[gi] = 1'b0;
        end else begin : g_src
            gw_state_e state_reg;
            logic      claim_hit;
            logic      complete_hit;
            logic      edge_evt;
            logic      trigger;
            logic      requeue;

            assign edge_evt = le_i[gi] & intr_src_i[gi] & ~src_q_reg[gi];
            assign trigger  = le_i[gi] ? edge_evt : intr_src_i[gi];

            // Several targets may name the same source in one cycle; they merge into one hit.
            always_comb begin
                claim_hit    = 1'b0;
                complete_hit = 1'b0;
                for (int t = 0; t < NumTarget; t++) begin
                    if (claim_i[t] && irq_id_o[t*SRCW +: SRCW] == SRCW'(gi)) begin
                        claim_hit = 1'b1;
                    end
                    if (complete_i[t] && complete_id_i[t*SRCW +: SRCW] == SRCW'(gi)) begin
                        complete_hit = 1'b1;
                    end
                end
            end

`ifdef RV_PLIC_EDGE_CNT_EN
            logic [3:0] cnt_reg;
            logic [3:0] cnt_sat;
            logic       le_q_reg;

            // Edges seen while busy are banked (saturating) and replayed one per completion.
            assign cnt_sat = (edge_evt && state_reg != GW_IDLE && cnt_reg != 4'hf)
                             ? cnt_reg + 4'd1 : cnt_reg;
            assign requeue = (cnt_sat != 4'd0);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg  <= '0;
                    le_q_reg <= 1'b0;
                end else begin
                    le_q_reg <= le_i[gi];
                    if (le_q_reg && !le_i[gi]) begin
                        cnt_reg <= '0;
                    end else if (state_reg == GW_CLAIMED && complete_hit && requeue) begin
                        cnt_reg <= cnt_sat - 4'd1;
                    end else begin
                        cnt_reg <= cnt_sat;
                    end
                end
            end
`else
            assign requeue = 1'b0;
`endif

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_reg <= GW_IDLE;
                end else begin
                    case (state_reg)
                        GW_IDLE:    if (trigger) state_reg <= GW_PENDING;
                        GW_PENDING: if (claim_hit) state_reg <= GW_CLAIMED;
                        GW_CLAIMED: if (complete_hit) state_reg <= requeue ? GW_PENDING : GW_IDLE;
                        default:    state_reg <= GW_IDLE;
                    endcase
                end
            end

            assign ip_o[gi] = (state_reg == GW_PENDING);
        end
    end

    for (gi = 0; gi < NumTarget; gi++) begin : g_tgt
        logic [PRIOW-1:0] best_prio;
        logic [SRCW-1:0]  best_id;
        logic [SRCW-1:0]  id_reg;
        logic             irq_reg;
        logic             unused_ie0;

        assign unused_ie0 = ie_i[gi*NumSrc];

        // Strict '>' while scanning upward keeps the lowest ID on ties and skips prio 0.
        always_comb begin
            best_prio = '0;
            best_id   = '0;
            for (int s = 1; s < NumSrc; s++) begin
                if (ip_o[s] && ie_i[gi*NumSrc + s] && prio_i[s*PRIOW +: PRIOW] > best_prio) begin
                    best_prio = prio_i[s*PRIOW +: PRIOW];
                    best_id   = SRCW'(s);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                id_reg  <= '0;
                irq_reg <= 1'b0;
            end else begin
                id_reg  <= best_id;
                irq_reg <= (best_prio > threshold_i[gi*PRIOW +: PRIOW]);
            end
        end

        assign irq_id_o[gi*SRCW +: SRCW] = id_reg;
        assign irq_o[gi]                 = irq_reg;
    end
endmodule

// File: tb/tb_rv_plic_core_mt.sv
// Bench for rv_plic_core_mt: directed vector table, corner-case sequences, randomized run vs reference model.
module tb_rv_plic_core_mt;
    localparam int NS = 32;
    localparam int NT = 2;
    localparam int PW = 3;
    localparam int SW = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NS-1:0]   intr_src_i = '0;
    logic [NS-1:0]   le_i = '0;
    logic [NS*PW-1:0] prio_i = '0;
    logic [NT*NS-1:0] ie_i = '0;
    logic [NT*PW-1:0] threshold_i = '0;
    logic [NT-1:0]   claim_i = '0;
    logic [NT-1:0]   complete_i = '0;
    logic [NT*SW-1:0] complete_id_i = '0;
    logic [NS-1:0]   ip_o;
    logic [NT-1:0]   irq_o;
    logic [NT*SW-1:0] irq_id_o;

    always #5 clk_i = ~clk_i;

    rv_plic_core_mt #(.NumSrc(NS), .NumTarget(NT), .MaxPrio(7)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .intr_src_i(intr_src_i), .le_i(le_i),
        .prio_i(prio_i), .ie_i(ie_i), .threshold_i(threshold_i), .claim_i(claim_i),
        .complete_i(complete_i), .complete_id_i(complete_id_i), .ip_o(ip_o),
        .irq_o(irq_o), .irq_id_o(irq_id_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_prio(input int s, input int p);
        prio_i[s*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        intr_src_i = '0; claim_i = '0; complete_i = '0; complete_id_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Reference model: gateway state per source (0 idle, 1 pending, 2 in service).
    int  m_st [NS];
    int  m_cnt[NS];
    bit  m_srcq[NS];
    int  m_id [NT];
    bit  m_irq[NT];
    bit  model_on = 1'b0;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin m_st[s] = 0; m_cnt[s] = 0; m_srcq[s] = 1'b0; end
        for (int t = 0; t < NT; t++) begin m_id[t] = 0; m_irq[t] = 1'b0; end
    endtask

    task automatic model_step();
        int new_id [NT];
        bit new_irq[NT];
        for (int t = 0; t < NT; t++) begin
            int best;
            best = 0; new_id[t] = 0;
            for (int s = 1; s < NS; s++) begin
                if (m_st[s] == 1 && ie_i[t*NS + s] && int'(prio_i[s*PW +: PW]) > best) begin
                    best = int'(prio_i[s*PW +: PW]);
                    new_id[t] = s;
                end
            end
            new_irq[t] = best > int'(threshold_i[t*PW +: PW]);
        end
        for (int s = 1; s < NS; s++) begin
            bit ev, trig, ch, cc;
            ev   = le_i[s] && intr_src_i[s] && !m_srcq[s];
            trig = le_i[s] ? ev : intr_src_i[s];
            ch = 1'b0; cc = 1'b0;
            for (int t = 0; t < NT; t++) begin
                if (claim_i[t] && m_id[t] == s) ch = 1'b1;
                if (complete_i[t] && int'(complete_id_i[t*SW +: SW]) == s) cc = 1'b1;
            end
            if (m_st[s] == 0) begin
                if (trig) m_st[s] = 1;
            end else begin
`ifdef RV_PLIC_EDGE_CNT_EN
                if (ev && m_cnt[s] < 15) m_cnt[s]++;
`endif
                if (m_st[s] == 1 && ch) begin
                    m_st[s] = 2;
                end else if (m_st[s] == 2 && cc) begin
                    m_st[s] = 0;
`ifdef RV_PLIC_EDGE_CNT_EN
                    if (m_cnt[s] > 0) begin m_st[s] = 1; m_cnt[s]--; end
`endif
                end
            end
            m_srcq[s] = intr_src_i[s];
        end
        m_id  = new_id;
        m_irq = new_irq;
    endtask

    always @(posedge clk_i) if (model_on) model_step();

    typedef struct {
        bit            rst;
        logic [NS-1:0] src;
        logic [NT-1:0] clm;
        logic [NT-1:0] cmp;
        logic [SW-1:0] cid0;
        logic [NS-1:0] eip;
        logic [NT-1:0] eirq;
        logic [SW-1:0] eid0;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mkv(bit r, logic [NS-1:0] src, logic [NT-1:0] clm, logic [NT-1:0] cmp,
                                 logic [SW-1:0] cid0, logic [NS-1:0] eip, logic [NT-1:0] eirq,
                                 logic [SW-1:0] eid0);
        vec_t v;
        v.rst = r; v.src = src; v.clm = clm; v.cmp = cmp; v.cid0 = cid0;
        v.eip = eip; v.eirq = eirq; v.eid0 = eid0;
        return v;
    endfunction

    initial begin
        logic [NS-1:0] exp_ip;
        // Level source 5 round trip, then the 3/7/9 priority and tie-break walk.
        vecs[0]  = mkv(0, 32'h20,  2'b00, 2'b00, 5'd0, 32'h20,  2'b00, 5'd0);
        vecs[1]  = mkv(0, 32'h20,  2'b00, 2'b00, 5'd0, 32'h20,  2'b01, 5'd5);
        vecs[2]  = mkv(0, 32'h20,  2'b01, 2'b00, 5'd0, 32'h0,   2'b01, 5'd5);
        vecs[3]  = mkv(0, 32'h20,  2'b00, 2'b00, 5'd0, 32'h0,   2'b00, 5'd0);
        vecs[4]  = mkv(0, 32'h20,  2'b00, 2'b01, 5'd5, 32'h0,   2'b00, 5'd0);
        vecs[5]  = mkv(0, 32'h20,  2'b00, 2'b00, 5'd0, 32'h20,  2'b00, 5'd0);
        vecs[6]  = mkv(0, 32'h20,  2'b00, 2'b00, 5'd0, 32'h20,  2'b01, 5'd5);
        vecs[7]  = mkv(1, 32'h288, 2'b00, 2'b00, 5'd0, 32'h288, 2'b00, 5'd0);
        vecs[8]  = mkv(0, 32'h288, 2'b00, 2'b00, 5'd0, 32'h288, 2'b01, 5'd9);
        vecs[9]  = mkv(0, 32'h288, 2'b01, 2'b00, 5'd0, 32'h088, 2'b01, 5'd9);
        vecs[10] = mkv(0, 32'h288, 2'b00, 2'b00, 5'd0, 32'h088, 2'b01, 5'd3);
        vecs[11] = mkv(0, 32'h288, 2'b01, 2'b00, 5'd0, 32'h080, 2'b01, 5'd3);
        vecs[12] = mkv(0, 32'h288, 2'b00, 2'b00, 5'd0, 32'h080, 2'b01, 5'd7);
        vecs[13] = mkv(0, 32'h288, 2'b01, 2'b00, 5'd0, 32'h000, 2'b01, 5'd7);
        vecs[14] = mkv(0, 32'h288, 2'b00, 2'b00, 5'd0, 32'h000, 2'b00, 5'd0);

        set_prio(5, 3); set_prio(3, 2); set_prio(7, 2); set_prio(9, 4);
        ie_i = {32'h0, 32'h2A8};

        @(negedge clk_i);
        chk("reset_ip", ip_o, 0);
        chk("reset_irq", irq_o, 0);
        chk("reset_id", irq_id_o, 0);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            intr_src_i = vecs[i].src; claim_i = vecs[i].clm; complete_i = vecs[i].cmp;
            complete_id_i = {5'd0, vecs[i].cid0};
            @(negedge clk_i);
            chk($sformatf("vec%0d_ip", i), ip_o, vecs[i].eip);
            chk($sformatf("vec%0d_irq", i), irq_o, vecs[i].eirq);
            chk($sformatf("vec%0d_id0", i), irq_id_o[SW-1:0], vecs[i].eid0);
            chk($sformatf("vec%0d_id1", i), irq_id_o[2*SW-1:SW], 0);
        end

        // Threshold: winner at prio 4 against threshold 4 is reported but not signalled.
        ie_i = {32'h200, 32'h2A8}; threshold_i = {3'd4, 3'd0};
        do_reset();
        intr_src_i = 32'h200;
        cyc(2);
        chk("thr_irq1_low", irq_o[1], 0);
        chk("thr_id1", irq_id_o[2*SW-1:SW], 9);
        chk("thr_irq0", irq_o[0], 1);
        threshold_i = {3'd3, 3'd0};
        cyc(1);
        chk("thr_irq1_high", irq_o[1], 1);

        // Both targets claim ID 12 together; completion comes from target 1.
        threshold_i = '0; ie_i = {32'h1000, 32'h1000}; set_prio(12, 1);
        do_reset();
        intr_src_i = 32'h1000; cyc(1);
        intr_src_i = '0; cyc(1);
        chk("dual_id0", irq_id_o[SW-1:0], 12);
        chk("dual_id1", irq_id_o[2*SW-1:SW], 12);
        claim_i = 2'b11; cyc(1); claim_i = '0;
        chk("dual_ip_clear", ip_o, 0);
        cyc(1);
        chk("dual_ids_zero", irq_id_o, 0);
        complete_i = 2'b01; complete_id_i = {5'd0, 5'd4}; cyc(1);
        chk("cmp_idle_ip", ip_o, 0);
        chk("cmp_idle_irq", irq_o, 0);
        complete_i = 2'b10; complete_id_i = {5'd12, 5'd0}; cyc(1);
        complete_i = '0; intr_src_i = 32'h1000; cyc(1);
        chk("dual_repend", ip_o[12], 1);

        // Edge source 2 gets three more pulses while in service.
        ie_i = {32'h0, 32'h4}; le_i = 32'h4; set_prio(2, 1);
        do_reset();
        intr_src_i = 32'h4; cyc(1); intr_src_i = '0;
        chk("edge_ip", ip_o[2], 1);
        cyc(1);
        chk("edge_id", irq_id_o[SW-1:0], 2);
        claim_i = 2'b01; cyc(1); claim_i = '0;
        chk("edge_claimed", ip_o[2], 0);
        repeat (3) begin intr_src_i = 32'h4; cyc(1); intr_src_i = '0; cyc(1); end
        chk("edge_busy_ip", ip_o[2], 0);
        complete_i = 2'b01; complete_id_i = {5'd0, 5'd2}; cyc(1); complete_i = '0;
`ifdef RV_PLIC_EDGE_CNT_EN
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("edge_round%0d_ip", r), ip_o[2], 1);
            cyc(1);
            chk($sformatf("edge_round%0d_id", r), irq_id_o[SW-1:0], 2);
            claim_i = 2'b01; cyc(1); claim_i = '0;
            chk($sformatf("edge_round%0d_clr", r), ip_o[2], 0);
            complete_i = 2'b01; cyc(1); complete_i = '0;
        end
`endif
        chk("edge_done_ip", ip_o[2], 0);
        cyc(2);
        chk("edge_done_ip2", ip_o[2], 0);
        chk("edge_done_irq", irq_o[0], 0);

        // Asynchronous reset while source 6 is in service and irq is still high.
        le_i = '0; ie_i = {32'h0, 32'h40}; set_prio(6, 5);
        do_reset();
        intr_src_i = 32'h40; cyc(2);
        chk("rst_pre_id", irq_id_o[SW-1:0], 6);
        claim_i = 2'b01; cyc(1); claim_i = '0;
        chk("rst_pre_irq", irq_o[0], 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_async_ip", ip_o, 0);
        chk("rst_async_irq", irq_o, 0);
        chk("rst_async_id", irq_id_o, 0);
        @(negedge clk_i);
        chk("rst_held_ip", ip_o, 0);
        rst_ni = 1'b1;
        cyc(1);
        chk("rst_repend", ip_o[6], 1);

        // Randomized run against the reference model.
        le_i = $urandom; prio_i = {$urandom, $urandom, $urandom};
        ie_i = {$urandom, $urandom}; threshold_i = 6'($urandom_range(0, 63));
        do_reset();
        model_reset();
        model_on = 1'b1;
        for (int c = 0; c < 500; c++) begin
            for (int s = 1; s < NS; s++)
                if ($urandom_range(0, 5) == 0) intr_src_i[s] = ~intr_src_i[s];
            for (int t = 0; t < NT; t++) begin
                int q[$];
                int cid;
                claim_i[t]    = ($urandom_range(0, 2) == 0);
                complete_i[t] = ($urandom_range(0, 2) == 0);
                cid = $urandom_range(0, NS - 1);
                for (int s = 1; s < NS; s++) if (m_st[s] == 2) q.push_back(s);
                if (q.size() > 0 && $urandom_range(0, 3) != 0) cid = q[$urandom_range(0, q.size() - 1)];
                complete_id_i[t*SW +: SW] = SW'(cid);
            end
            if ($urandom_range(0, 19) == 0) threshold_i = 6'($urandom_range(0, 63));
            @(negedge clk_i);
            for (int s = 0; s < NS; s++) exp_ip[s] = (m_st[s] == 1);
            chk($sformatf("rnd%0d_ip", c), ip_o, exp_ip);
            for (int t = 0; t < NT; t++) begin
                chk($sformatf("rnd%0d_irq%0d", c, t), irq_o[t], m_irq[t]);
                chk($sformatf("rnd%0d_id%0d", c, t), irq_id_o[t*SW +: SW], m_id[t]);
            end
        end
        model_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
